// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: evaluates the branch condition, issues a registered
// one-cycle redirect, squashes the two younger pipeline slots, and keeps saturating statistics.
module branch_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_e,
  input  logic             valid_e,
  input  logic             branch_e,
  input  logic             jump_e,
  input  logic             jalr_e,
  input  logic [2:0]       funct3_e,
  input  logic             Z,
  input  logic             N,
  input  logic             V,
  input  logic             C,
  input  logic [31:0]      result_e,
  input  logic [31:0]      pc_e,
  input  logic [31:0]      imm_e,
  output logic             pc_src,
  output logic [31:0]      pc_target,
  output logic             flush_d,
  output logic             flush_e,
  output logic             illegal_br,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] resolved_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQ1  = 2'd1;
  localparam logic [1:0] SQ2  = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

  function automatic logic br_cond(input logic [2:0] f3, input logic z, input logic n,
                                   input logic v, input logic c);
    logic res;
    case (f3)
      3'b000:  res = z;
      3'b001:  res = ~z;
      3'b100:  res = n ^ v;
      3'b101:  res = ~(n ^ v);
      3'b110:  res = ~c;
      3'b111:  res = c;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic br_reserved(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  logic [1:0]       state_q, state_d;
  logic             pc_src_q, pc_src_d;
  logic [31:0]      pc_target_q, pc_target_d;
  logic             flush_d_q, flush_d_d;
  logic             flush_e_q, flush_e_d;
  logic             illegal_br_q, illegal_br_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] resolved_cnt_q, resolved_cnt_d;

  logic             eval;
  logic             taken;
  logic             illegal;
  logic signed [31:0] pc_s;
  logic signed [31:0] imm_s;
  logic [31:0]      rel_target;
  logic [31:0]      target;

  // Wrong-path instructions arriving during SQ1/SQ2 never reach eval.
  assign eval    = (state_q == IDLE) && valid_e && !stall_e && (branch_e || jump_e);
  assign taken   = jump_e || (branch_e && br_cond(funct3_e, Z, N, V, C));
  assign illegal = branch_e && !jump_e && br_reserved(funct3_e);

  assign pc_s       = signed'(pc_e);
  assign imm_s      = signed'(imm_e);
  assign rel_target = unsigned'(pc_s + imm_s);
  assign target     = (jump_e && jalr_e) ? (result_e & ~32'h1) : rel_target;

  always_comb begin
    state_d        = state_q;
    pc_src_d       = pc_src_q;
    pc_target_d    = pc_target_q;
    flush_d_d      = flush_d_q;
    flush_e_d      = flush_e_q;
    illegal_br_d   = illegal_br_q;
    taken_cnt_d    = taken_cnt_q;
    resolved_cnt_d = resolved_cnt_q;
    if (!stall_e) begin
      illegal_br_d = 1'b0;
      case (state_q)
        IDLE: begin
          pc_src_d  = 1'b0;
          flush_d_d = 1'b0;
          flush_e_d = 1'b0;
          if (eval) begin
            resolved_cnt_d = sat_inc(resolved_cnt_q);
            illegal_br_d   = illegal;
            if (taken) begin
              state_d     = SQ1;
              pc_src_d    = 1'b1;
              pc_target_d = target;
              flush_d_d   = 1'b1;
              flush_e_d   = 1'b1;
              taken_cnt_d = sat_inc(taken_cnt_q);
            end
          end
        end
        SQ1: begin
          state_d   = SQ2;
          pc_src_d  = 1'b0;
          flush_d_d = 1'b1;
          flush_e_d = 1'b1;
        end
        SQ2: begin
          state_d   = IDLE;
          pc_src_d  = 1'b0;
          flush_d_d = 1'b0;
          flush_e_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          pc_src_d  = 1'b0;
          flush_d_d = 1'b0;
          flush_e_d = 1'b0;
        end
      endcase
    end
  end

  // Reset wins over stall and abandons any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_src_q       <= 1'b0;
      pc_target_q    <= 32'h0;
      flush_d_q      <= 1'b0;
      flush_e_q      <= 1'b0;
      illegal_br_q   <= 1'b0;
      taken_cnt_q    <= '0;
      resolved_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_src_q       <= pc_src_d;
      pc_target_q    <= pc_target_d;
      flush_d_q      <= flush_d_d;
      flush_e_q      <= flush_e_d;
      illegal_br_q   <= illegal_br_d;
      taken_cnt_q    <= taken_cnt_d;
      resolved_cnt_q <= resolved_cnt_d;
    end
  end

  assign pc_src       = pc_src_q;
  assign pc_target    = pc_target_q;
  assign flush_d      = flush_d_q;
  assign flush_e      = flush_e_q;
  assign illegal_br   = illegal_br_q;
  assign taken_cnt    = taken_cnt_q;
  assign resolved_cnt = resolved_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a default-width instance plus a CNT_W=2 instance
// sharing the same stimulus so counter saturation can be observed.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, stall_e, valid_e, branch_e, jump_e, jalr_e;
  logic [2:0]  funct3_e;
  logic        z, n, v, c;
  logic [31:0] result_e, pc_e, imm_e;

  logic        pc_src, flush_d, flush_e, illegal_br;
  logic [31:0] pc_target;
  logic [15:0] taken_cnt, resolved_cnt;

  logic        pc_src2, flush_d2, flush_e2, illegal_br2;
  logic [31:0] pc_target2;
  logic [1:0]  taken_cnt2, resolved_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .valid_e(valid_e), .branch_e(branch_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e), .Z(z), .N(n), .V(v), .C(c),
    .result_e(result_e), .pc_e(pc_e), .imm_e(imm_e), .pc_src(pc_src), .pc_target(pc_target),
    .flush_d(flush_d), .flush_e(flush_e), .illegal_br(illegal_br), .taken_cnt(taken_cnt),
    .resolved_cnt(resolved_cnt)
  );

  branch_resolve #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall_e(stall_e), .valid_e(valid_e), .branch_e(branch_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e), .Z(z), .N(n), .V(v), .C(c),
    .result_e(result_e), .pc_e(pc_e), .imm_e(imm_e), .pc_src(pc_src2), .pc_target(pc_target2),
    .flush_d(flush_d2), .flush_e(flush_e2), .illegal_br(illegal_br2), .taken_cnt(taken_cnt2),
    .resolved_cnt(resolved_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_e = 0; branch_e = 0; jump_e = 0; jalr_e = 0; funct3_e = 3'b000;
    z = 0; n = 0; v = 0; c = 0; result_e = 0; pc_e = 0; imm_e = 0;
  endtask

  task automatic outs(input string tag, input logic src, input logic fd, input logic fe);
    check({tag, ".pc_src"}, {31'b0, pc_src}, {31'b0, src});
    check({tag, ".flush_d"}, {31'b0, flush_d}, {31'b0, fd});
    check({tag, ".flush_e"}, {31'b0, flush_e}, {31'b0, fe});
  endtask

  task automatic cnts(input string tag, input int tk, input int rs);
    check({tag, ".taken_cnt"}, {16'b0, taken_cnt}, tk);
    check({tag, ".resolved_cnt"}, {16'b0, resolved_cnt}, rs);
  endtask

  initial begin
    idle_inputs();
    stall_e = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    outs("reset", 0, 0, 0);
    check("reset.pc_target", pc_target, 32'h0);
    check("reset.illegal_br", {31'b0, illegal_br}, 32'h0);
    cnts("reset", 0, 0);

    // Taken BEQ right after reset release
    valid_e = 1; branch_e = 1; funct3_e = 3'b000; z = 1; pc_e = 32'h100; imm_e = 32'h20;
    tick();
    idle_inputs();
    outs("beq.sq1", 1, 1, 1);
    check("beq.target", pc_target, 32'h120);
    cnts("beq.sq1", 1, 1);
    tick();
    outs("beq.sq2", 0, 1, 1);
    tick();
    outs("beq.idle", 0, 0, 0);
    check("beq.target_hold", pc_target, 32'h120);
    cnts("beq.idle", 1, 1);

    // BLT with N=V and BLTU with C=1: both not taken
    valid_e = 1; branch_e = 1; funct3_e = 3'b100; n = 1; v = 1;
    tick();
    outs("blt", 0, 0, 0);
    cnts("blt", 1, 2);
    funct3_e = 3'b110; n = 0; v = 0; c = 1;
    tick();
    idle_inputs();
    outs("bltu", 0, 0, 0);
    cnts("bltu", 1, 3);

    // JALR with odd target, then a taken BEQ on the wrong path
    valid_e = 1; jump_e = 1; jalr_e = 1; result_e = 32'h0000_2003; pc_e = 32'h100; imm_e = 32'h20;
    tick();
    idle_inputs();
    outs("jalr.sq1", 1, 1, 1);
    check("jalr.target", pc_target, 32'h0000_2002);
    cnts("jalr.sq1", 2, 4);
    valid_e = 1; branch_e = 1; funct3_e = 3'b000; z = 1; pc_e = 32'h300; imm_e = 32'h4;
    tick();
    outs("wrongpath.sq2", 0, 1, 1);
    cnts("wrongpath.sq2", 2, 4);
    tick();
    idle_inputs();
    outs("wrongpath.idle", 0, 0, 0);
    check("wrongpath.target", pc_target, 32'h0000_2002);
    check("wrongpath.illegal", {31'b0, illegal_br}, 32'h0);
    cnts("wrongpath.idle", 2, 4);

    // Taken BNE with a negative offset, then a 3-cycle stall over SQ1
    valid_e = 1; branch_e = 1; funct3_e = 3'b001; z = 0; pc_e = 32'h400; imm_e = 32'hFFFF_FFF0;
    tick();
    idle_inputs();
    outs("bne.sq1", 1, 1, 1);
    check("bne.target", pc_target, 32'h3F0);
    cnts("bne.sq1", 3, 5);
    stall_e = 1;
    valid_e = 1; jump_e = 1; pc_e = 32'h800; imm_e = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("bne.stall", 1, 1, 1);
      check("bne.stall_target", pc_target, 32'h3F0);
      cnts("bne.stall", 3, 5);
    end
    stall_e = 0;
    idle_inputs();
    tick();
    outs("bne.sq2", 0, 1, 1);
    tick();
    outs("bne.idle", 0, 0, 0);

    // Reserved funct3: one-cycle strobe, then again with the strobe held by a stall
    valid_e = 1; branch_e = 1; funct3_e = 3'b010;
    tick();
    idle_inputs();
    check("illegal.strobe", {31'b0, illegal_br}, 32'h1);
    outs("illegal", 0, 0, 0);
    cnts("illegal", 3, 6);
    tick();
    check("illegal.clear", {31'b0, illegal_br}, 32'h0);
    valid_e = 1; branch_e = 1; funct3_e = 3'b011;
    tick();
    idle_inputs();
    check("illegal2.strobe", {31'b0, illegal_br}, 32'h1);
    stall_e = 1;
    tick();
    check("illegal2.held", {31'b0, illegal_br}, 32'h1);
    stall_e = 0;
    tick();
    check("illegal2.clear", {31'b0, illegal_br}, 32'h0);
    cnts("illegal2", 3, 7);

    // Jump has priority over a simultaneous reserved-funct3 branch
    valid_e = 1; jump_e = 1; branch_e = 1; funct3_e = 3'b010; pc_e = 32'h1000; imm_e = 32'h8;
    result_e = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    outs("prio.sq1", 1, 1, 1);
    check("prio.target", pc_target, 32'h1008);
    check("prio.illegal", {31'b0, illegal_br}, 32'h0);
    cnts("prio", 4, 8);
    tick();
    tick();

    // Reset during SQ2 while stalled
    valid_e = 1; jump_e = 1; pc_e = 32'h40; imm_e = 32'h4;
    tick();
    idle_inputs();
    tick();
    outs("rst.sq2", 0, 1, 1);
    rst = 1; stall_e = 1;
    tick();
    rst = 0; stall_e = 0;
    outs("rst.sq2_clear", 0, 0, 0);
    check("rst.sq2_target", pc_target, 32'h0);
    cnts("rst.sq2", 0, 0);
    check("rst.dut2_taken", {30'b0, taken_cnt2}, 32'h0);
    tick();
    outs("rst.abandoned", 0, 0, 0);

    // Five taken jumps: the 2-bit counters stop at 3
    for (int k = 0; k < 5; k++) begin
      valid_e = 1; jump_e = 1; pc_e = 32'h2000; imm_e = k * 4;
      tick();
      idle_inputs();
      check("sat.target", pc_target, 32'h2000 + k * 4);
      tick();
      tick();
    end
    check("sat.dut2_taken", {30'b0, taken_cnt2}, 32'h3);
    check("sat.dut2_resolved", {30'b0, resolved_cnt2}, 32'h3);
    cnts("sat.dut", 5, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating branch-statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_e  input  1  EX stage held; block freezes all state and outputs.
REQ-005 valid_e  input  1  EX stage holds a live instruction.
REQ-006 branch_e  input  1  EX instruction is a conditional branch.
REQ-007 jump_e  input  1  EX instruction is JAL or JALR.
REQ-008 jalr_e  input  1  with jump_e: target comes from result_e, not PC+imm.
REQ-009 funct3_e  input  3  branch condition code.
REQ-010 Z, N, V, C  input  1 each  ALU flags for the EX compare (rs1 - rs2).
REQ-011 result_e  input  32  ALU result, the JALR target sum.
REQ-012 pc_e  input  32  EX instruction PC.
REQ-013 imm_e  input  32  sign-extended branch/JAL offset.
REQ-014 pc_src  output  1  one-cycle redirect strobe to the fetch PC mux.
REQ-015 pc_target  output  32  redirect address, valid while pc_src=1.
REQ-016 flush_d  output  1  squash IF/ID register.
REQ-017 flush_e  output  1  squash ID/EX register.
REQ-018 illegal_br  output  1  one-cycle strobe for a branch with reserved funct3.
REQ-019 taken_cnt  output  CNT_W  count of redirects issued.
REQ-020 resolved_cnt  output  CNT_W  count of branches and jumps evaluated.

Function
REQ-021 An instruction is evaluated only when state=IDLE, valid_e=1, stall_e=0, and branch_e or jump_e is 1.
REQ-022 Conditions: 000 BEQ Z; 001 BNE ~Z; 100 BLT N^V; 101 BGE ~(N^V); 110 BLTU ~C; 111 BGEU C.
REQ-023 funct3 010 or 011 with branch_e is not taken; illegal_br=1 for the following cycle only.
REQ-024 jump_e is unconditionally taken and has priority over branch_e when both are set.
REQ-025 Target is pc_e+imm_e (mod 2^32) for branches and JAL, and {result_e[31:1],1'b0} for JALR.
REQ-026 All outputs are registered; taken-path response appears exactly one cycle after the evaluating edge.
REQ-027 FSM states: IDLE, SQ1, SQ2.
REQ-028 IDLE -> SQ1 on a taken evaluation; otherwise stay in IDLE.
REQ-029 SQ1 -> SQ2 -> IDLE unconditionally, each on one unstalled cycle.
REQ-030 In SQ1: pc_src=1, pc_target latched, flush_d=1, flush_e=1.
REQ-031 In SQ2: pc_src=0, flush_d=1, flush_e=1.
REQ-032 In IDLE: pc_src, flush_d, and flush_e are 0.
REQ-033 In SQ1/SQ2, incoming valid_e/branch_e/jump_e are wrong-path: ignored, no counting, no illegal_br.
REQ-034 pc_target holds its last latched value outside SQ1.
REQ-035 stall_e=1 in any state holds the state, all outputs, and counters; illegal_br strobe also holds.
REQ-036 resolved_cnt increments by 1 per evaluation; taken_cnt increments by 1 per IDLE->SQ1 transition.
REQ-037 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-038 Back-to-back taken branches: the second arrives during SQ1/SQ2 and is squashed per REQ-033.

Reset
REQ-039 rst=1 at a clock edge forces, on that edge: state=IDLE, pc_src=0, pc_target=0, flush_d=0, flush_e=0, illegal_br=0, both counters=0.
REQ-040 rst overrides stall_e and any in-progress squash; a redirect pending in SQ1/SQ2 is abandoned.
REQ-041 The first evaluation is possible in the cycle after rst deasserts.

Verification
REQ-042 BEQ, Z=1, pc_e=0x100, imm_e=0x20 -> next cycle: pc_src=1, pc_target=0x120, flush_d=flush_e=1; then one flush-only cycle; then IDLE; taken_cnt=1, resolved_cnt=1.
REQ-043 BLT with N=1,V=1, then BLTU with C=1 -> neither taken; flushes stay 0; resolved_cnt=2, taken_cnt=0.
REQ-044 JALR, result_e=0x0000_2003 -> pc_target=0x0000_2002, pc_src=1; the taken BEQ presented in the next cycle is ignored and counters move by 1 only.
REQ-045 Taken BNE with stall_e=1 held for 3 cycles after the response starts -> SQ1 outputs held for 3 cycles, then SQ2, then IDLE.
REQ-046 rst asserted during SQ2 -> all outputs 0 on that edge; with CNT_W=2 and 5 taken jumps, taken_cnt=3.
REQ-047 funct3=010 with branch_e -> illegal_br=1 for exactly one cycle; pc_src=0; resolved_cnt increments by 1.
